sequence_framer_tx: RTL and testbench
=====================================

Name: sequence_framer_tx

Overview:
- Serial frame transmitter: wraps a parallel payload word between a fixed header bit pattern and a fixed trailer bit pattern.
- Shifts the frame out one bit at a time, MSB first.
- Sits on the transmit side of the SPI slave driver path; frames are built so a downstream 2-pattern serial detector flags the header and trailer on their last bit.
- Parallel side uses a valid/ready handshake; serial side emits a bit stream plus a bit strobe.

Parameters:
- width, 8, header/trailer pattern length in bits (≥2)
- data_width, 16, payload length in bits (≥1)
- head_sequence, 8'h0f, header pattern, sent MSB first
- tail_sequence, 8'hf0, trailer pattern, sent MSB first
- bit_div, 1, clock cycles per serial bit (≥1)
- idle_level, 1'b0, sequence_out value when not transmitting

Ports:
- clk, input, 1, system clock; all logic on the rising edge
- rst, input, 1, synchronous active-high reset
- data_in, input, data_width, payload word
- data_valid, input, 1, payload offered
- data_ready, output, 1, transmitter can accept a payload
- sequence_out, output, 1, serial frame bit
- bit_strobe, output, 1, one-cycle pulse on the first clock of every frame bit
- busy, output, 1, frame in progress
- frame_done, output, 1, one-cycle pulse after the last trailer bit completes

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, sequence_out=idle_level, data_ready=1, busy=0, bit_strobe=0, frame_done=0. Bit counter, divider counter and shift register are cleared to 0.
- FSM states: IDLE, HEAD, DATA, (PARITY), TAIL.
- IDLE:
  - data_ready=1.
  - A transfer is accepted when data_valid && data_ready at an edge. data_in is latched into the shift register and the FSM goes to HEAD.
  - data_valid is ignored while data_ready=0; no buffering of a second word.
- Latency: the first header bit (head_sequence[width-1]) appears on sequence_out, with bit_strobe=1, in the cycle right after acceptance.
- HEAD:
  - Sends head_sequence[width-1] down to [0].
  - Each bit is held for exactly bit_div cycles; a divider counter runs 0..bit_div-1.
  - After bit 0 the FSM goes to DATA.
- DATA: sends data_in[data_width-1] down to [0] from the latched copy. Changes to data_in after acceptance have no effect.
- TAIL:
  - Sends tail_sequence[width-1] down to [0].
  - On the last cycle of bit 0 the FSM goes to IDLE.
  - In the first IDLE cycle: frame_done=1, data_ready=1, sequence_out=idle_level.
- busy=1 in every non-IDLE state.
- Frame length: width + data_width + width bits (plus 1 with the parity option), times bit_div cycles.
- Back-to-back frames: a word accepted in the frame_done cycle starts its header on the next cycle. Minimum inter-frame gap is one clock at idle_level.
- Bit counter: sized clog2(max(width, data_width)). It reloads at each state entry and must not wrap.
- bit_div=1: bit_strobe is held high continuously during a frame.
- Reset mid-frame: the frame is aborted at the next edge and all outputs return to reset values. No frame_done pulse is generated.
- rst and data_valid asserted together: reset wins; nothing is accepted.

Optional Feature:
- Macro: SEQ_FRAMER_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and TAIL.
  - It sends one bit equal to the even parity (XOR reduction) of the latched payload, held for bit_div cycles.
  - Frame length grows by one bit.
- Undefined: DATA goes directly to TAIL; no parity logic is synthesized.

Test Plan:
- Default params, bit_div=1, payload 16'hA55A:
  - sequence_out over 32 cycles = 0000_1111_1010_0101_0101_1010_1111_0000.
  - frame_done pulses at cycle 33 after acceptance.
  - Loopback into a width-8 pattern detector asserts the head match on cycle 8 and the tail match on cycle 32.
- bit_div=3, payload 16'h0001:
  - Each bit is held for exactly 3 cycles; bit_strobe pulses every 3rd cycle.
  - Frame spans 96 cycles; the LSB '1' is visible on cycles 70-72.
- Back-to-back, data_valid held high with 16'hFFFF then 16'h0000: second header starts the cycle after frame_done; exactly one idle cycle between frames.
- Payload change mid-frame: drive data_in=16'h1234, accept, then change to 16'hFFFF during HEAD → 16'h1234 is transmitted.
- Reset at cycle 12 of a frame → next cycle sequence_out=0, busy=0, data_ready=1; no frame_done pulse; a new frame then transmits correctly.
- SEQ_FRAMER_PARITY_EN defined, payload 16'h0007 → parity bit 1 at cycle 25, tail on cycles 26-33; with 16'h0003 the parity bit is 0.

Source files
------------

// File: rtl/sequence_framer_tx.sv
// Serial frame transmitter: header pattern, payload (MSB first) and trailer pattern on a bit stream.
// Optional even-parity bit between payload and trailer when SEQ_FRAMER_PARITY_EN is defined.
module sequence_framer_tx #(
  parameter int               width         = 8,
  parameter int               data_width    = 16,
  parameter logic [width-1:0] head_sequence = 8'h0f,
  parameter logic [width-1:0] tail_sequence = 8'hf0,
  parameter int               bit_div       = 1,
  parameter logic             idle_level    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  sequence_out,
  output logic                  bit_strobe,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int MAX_LEN = (width > data_width) ? width : data_width;
  localparam int CNT_W   = $clog2(MAX_LEN);
  localparam int DIV_W   = (bit_div > 1) ? $clog2(bit_div) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    DATA,
`ifdef SEQ_FRAMER_PARITY_EN
    PARITY,
`endif
    TAIL
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [width-1:0]      pat_sr;
  logic [data_width-1:0] data_sr;
`ifdef SEQ_FRAMER_PARITY_EN
  logic                  parity_bit;
`endif

  logic bit_end;
  logic bit_last;

  // A frame bit ends on the last divider cycle; the state's last bit ends when the counter is also 0.
  assign bit_end  = (div_cnt == DIV_W'(bit_div - 1));
  assign bit_last = bit_end && (bit_cnt == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (data_valid) state_next = HEAD;
      HEAD: if (bit_last) state_next = DATA;
`ifdef SEQ_FRAMER_PARITY_EN
      DATA:   if (bit_last) state_next = PARITY;
      PARITY: if (bit_end)  state_next = TAIL;
`else
      DATA: if (bit_last) state_next = TAIL;
`endif
      TAIL: if (bit_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      pat_sr     <= '0;
      data_sr    <= '0;
      frame_done <= 1'b0;
`ifdef SEQ_FRAMER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      frame_done <= (state == TAIL) && (state_next == IDLE);
      div_cnt    <= (state == IDLE || bit_end) ? '0 : div_cnt + DIV_W'(1);

      if (state_next != state) begin
        // Counters and shifters reload on every state entry; the counter never wraps.
        case (state_next)
          HEAD: begin
            pat_sr     <= head_sequence;
            data_sr    <= data_in;
            bit_cnt    <= CNT_W'(width - 1);
`ifdef SEQ_FRAMER_PARITY_EN
            parity_bit <= ^data_in;
`endif
          end
          DATA: bit_cnt <= CNT_W'(data_width - 1);
`ifdef SEQ_FRAMER_PARITY_EN
          PARITY: bit_cnt <= '0;
`endif
          TAIL: begin
            pat_sr  <= tail_sequence;
            bit_cnt <= CNT_W'(width - 1);
          end
          default: ;
        endcase
      end else if (bit_end && state != IDLE) begin
        bit_cnt <= bit_cnt - CNT_W'(1);
        case (state)
          HEAD, TAIL: pat_sr  <= pat_sr << 1;
          DATA:       data_sr <= data_sr << 1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    sequence_out = idle_level;
    case (state)
      HEAD, TAIL: sequence_out = pat_sr[width-1];
      DATA:       sequence_out = data_sr[data_width-1];
`ifdef SEQ_FRAMER_PARITY_EN
      PARITY:     sequence_out = parity_bit;
`endif
      default:    sequence_out = idle_level;
    endcase
  end

  assign busy       = (state != IDLE);
  assign data_ready = (state == IDLE);
  assign bit_strobe = busy && (div_cnt == '0);

endmodule

// File: tb/tb_sequence_framer_tx.sv
// Directed bench for sequence_framer_tx: bit_div=1 and bit_div=3 instances, hand-computed frames.
module tb_sequence_framer_tx;

`ifdef SEQ_FRAMER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB = 8 + 16 + PB + 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in1, data_in3;
  logic        valid1, valid3;
  logic        ready1, seq1, strobe1, busy1, done1;
  logic        ready3, seq3, strobe3, busy3, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sequence_framer_tx dut (
    .clk(clk), .rst(rst), .data_in(data_in1), .data_valid(valid1), .data_ready(ready1),
    .sequence_out(seq1), .bit_strobe(strobe1), .busy(busy1), .frame_done(done1)
  );

  sequence_framer_tx #(.bit_div(3)) dut3 (
    .clk(clk), .rst(rst), .data_in(data_in3), .data_valid(valid3), .data_ready(ready3),
    .sequence_out(seq3), .bit_strobe(strobe3), .busy(busy3), .frame_done(done3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected frame, right-aligned, first-sent bit at position FB-1.
  function automatic logic [63:0] frame_of(input logic [15:0] p);
    logic [63:0] f;
`ifdef SEQ_FRAMER_PARITY_EN
    f = {31'b0, 8'h0f, p, ^p, 8'hf0};
`else
    f = {32'b0, 8'h0f, p, 8'hf0};
`endif
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an idle cycle; returns in the frame_done cycle.
  task automatic frame1(input string tag, input logic [15:0] p, input logic [15:0] later,
                        input int change_at, output logic [63:0] bits);
    int bad = 0;
    bits = '0;
    data_in1 = p;
    valid1   = 1'b1;
    tick();
    valid1 = 1'b0;
    for (int c = 1; c <= FB; c++) begin
      if (c > 1) tick();
      if (c == change_at) data_in1 = later;
      bits = {bits[62:0], seq1};
      if (strobe1 !== 1'b1 || busy1 !== 1'b1 || ready1 !== 1'b0 || done1 !== 1'b0) bad++;
    end
    check({tag, "_bits"}, bits, frame_of(p));
    check({tag, "_ctl"}, 64'(bad), 64'd0);
    tick();
    check({tag, "_done"}, {done1, ready1, busy1, seq1}, 4'b1100);
  endtask

  initial begin
    logic [63:0] bits, bits2, f;
    logic [7:0]  win;
    int          head_at, tail_at, bad, bad_strobe, pulses;

    rst = 1'b1; valid1 = 1'b0; valid3 = 1'b0; data_in1 = '0; data_in3 = '0;
    tick(); tick();
    check("reset_dut1", {seq1, ready1, busy1, strobe1, done1}, 5'b01000);
    check("reset_dut3", {seq3, ready3, busy3, strobe3, done3}, 5'b01000);
    rst = 1'b0;
    tick();

    // Basic frame plus loopback pattern detection.
    frame1("a55a", 16'hA55A, 16'hA55A, 0, bits);
`ifndef SEQ_FRAMER_PARITY_EN
    check("a55a_literal", bits, 64'h0FA55AF0);
`endif
    win = '0; head_at = 0; tail_at = 0;
    for (int c = 1; c <= FB; c++) begin
      win = {win[6:0], bits[FB-c]};
      if (win == 8'h0f && head_at == 0) head_at = c;
      if (win == 8'hf0 && tail_at == 0) tail_at = c;
    end
    check("loop_head_at", 64'(head_at), 64'd8);
    check("loop_tail_at", 64'(tail_at), 64'(FB));
    tick();
    check("done_one_cycle", {done1, ready1}, 2'b01);

    // Payload changed during the header must not affect the frame.
    frame1("hold_1234", 16'h1234, 16'hFFFF, 3, bits);
    tick();

    // Back-to-back with data_valid held high.
    data_in1 = 16'hFFFF; valid1 = 1'b1;
    tick();
    data_in1 = 16'h0000;
    bits = '0;
    for (int c = 1; c <= FB; c++) begin
      if (c > 1) tick();
      bits = {bits[62:0], seq1};
    end
    check("b2b_first", bits, frame_of(16'hFFFF));
    tick();
    check("b2b_gap", {done1, ready1, busy1, seq1}, 4'b1100);
    tick();
    check("b2b_second_start", {busy1, strobe1, seq1, ready1}, 4'b1100);
    valid1 = 1'b0;
    bits2 = '0;
    for (int c = 1; c <= FB; c++) begin
      if (c > 1) tick();
      bits2 = {bits2[62:0], seq1};
    end
    check("b2b_second", bits2, frame_of(16'h0000));
    tick();
    check("b2b_done", {done1, ready1}, 2'b11);
    tick();

    // Reset in the middle of a frame.
    data_in1 = 16'h5A5A; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    for (int c = 2; c <= 12; c++) tick();
    check("mid_busy", 64'(busy1), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_outputs", {seq1, ready1, busy1, strobe1, done1}, 5'b01000);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done1 === 1'b1 || busy1 !== 1'b0) pulses++;
    end
    check("mid_rst_quiet", 64'(pulses), 64'd0);
    frame1("after_rst", 16'hC3A5, 16'hC3A5, 0, bits);
    tick();

    // Reset and data_valid together: nothing accepted.
    rst = 1'b1; valid1 = 1'b1; data_in1 = 16'hBEEF;
    tick();
    rst = 1'b0; valid1 = 1'b0;
    tick();
    check("rst_beats_valid", {busy1, ready1}, 2'b01);

    // Parity-sensitive payloads.
    frame1("p0007", 16'h0007, 16'h0007, 0, bits);
`ifdef SEQ_FRAMER_PARITY_EN
    check("parity_0007", 64'(bits[FB-25]), 64'd1);
`endif
    tick();
    frame1("p0003", 16'h0003, 16'h0003, 0, bits);
`ifdef SEQ_FRAMER_PARITY_EN
    check("parity_0003", 64'(bits[FB-25]), 64'd0);
`endif
    tick();

    // Divided bit clock on the second instance.
    f = frame_of(16'h0001);
    data_in3 = 16'h0001; valid3 = 1'b1;
    tick();
    valid3 = 1'b0;
    bad = 0; bad_strobe = 0;
    for (int c = 1; c <= 3 * FB; c++) begin
      if (c > 1) tick();
      if (seq3 !== f[FB - 1 - (c - 1) / 3]) bad++;
      if (strobe3 !== (((c - 1) % 3) == 0)) bad_strobe++;
      if (busy3 !== 1'b1 || done3 !== 1'b0) bad++;
      if (c >= 70 && c <= 72) check($sformatf("div3_lsb_c%0d", c), 64'(seq3), 64'd1);
    end
    check("div3_seq", 64'(bad), 64'd0);
    check("div3_strobe", 64'(bad_strobe), 64'd0);
    tick();
    check("div3_done", {done3, ready3, busy3, seq3}, 4'b1100);
    tick();
    check("div3_done_pulse", 64'(done3), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
